// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
//   Assembles 3-byte PS/2 mouse packets and integrates the signed movement
//   into a cursor clamped to the visible screen. Tracks a left-drag square
//   selection and emits single-cycle click / zoom / restore events.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data[7:0], rx_valid      byte stream from the PS/2 receiver
//   mouse_en                    tracking enable; rising edge reloads cursor
//   cursor_x_orig/_y_orig[10:0] cursor position loaded on mouse_en rise
//   cursor_x/_y[10:0]           current cursor (y = 0 is the top row)
//   left_pos_x, bot_pos_y       selection left edge / bottom edge
//   sel_length[9:0]             selection side length
//   sel_active                  left drag in progress
//   mouse_click/zoom/restore    single-cycle event pulses
module mouse_cursor_tracker #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int MIN_SEL = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        mouse_en,
  input  logic [10:0] cursor_x_orig,
  input  logic [10:0] cursor_y_orig,
  output logic [10:0] cursor_x,
  output logic [10:0] cursor_y,
  output logic [10:0] left_pos_x,
  output logic [10:0] bot_pos_y,
  output logic [9:0]  sel_length,
  output logic        sel_active,
  output logic        mouse_click,
  output logic        mouse_zoom,
  output logic        mouse_restore
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [12:0] X_MAX = 13'(H_RES - 1);
  localparam logic signed [12:0] Y_MAX = 13'(V_RES - 1);

  typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_UPD} state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic        en_prev_q;
  logic [10:0] cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [10:0] anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
  logic [10:0] left_pos_x_q, left_pos_x_d, bot_pos_y_q, bot_pos_y_d;
  logic [9:0]  sel_length_q, sel_length_d;
  logic        sel_active_q, sel_active_d;
  logic        left_hist_q, left_hist_d, right_hist_q, right_hist_d;
  logic        click_q, click_d, zoom_q, zoom_d, restore_q, restore_d;

  logic               en_rise;
  logic               left_btn, right_btn, ovf;
  logic signed [12:0] dx_s, dy_s, x_sum, y_sum;
  logic [10:0]        nx, ny;

  // Clamp a 13-bit signed coordinate to [0, hi] before narrowing to 11 bits.
  function automatic logic [10:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] hi);
    if (v < 13'sd0) return 11'd0;
    if (v > hi)     return hi[10:0];
    return v[10:0];
  endfunction

  // Square side = larger axis distance from the anchor, saturated to 10 bits.
  function automatic logic [9:0] sel_len(input logic [10:0] x, input logic [10:0] ax,
                                         input logic [10:0] y, input logic [10:0] ay);
    logic [10:0] ddx, ddy, m;
    ddx = (x >= ax) ? (x - ax) : (ax - x);
    ddy = (y >= ay) ? (y - ay) : (ay - y);
    m   = (ddx >= ddy) ? ddx : ddy;
    return (m > 11'd1023) ? 10'd1023 : m[9:0];
  endfunction

  assign en_rise   = mouse_en & ~en_prev_q;
  assign left_btn  = b0_q[0];
  assign right_btn = b0_q[1];
  assign ovf       = b0_q[6] | b0_q[7];
  assign dx_s      = {{4{b0_q[4]}}, b0_q[4], b1_q};
  assign dy_s      = {{4{b0_q[5]}}, b0_q[5], b2_q};
  assign x_sum     = $signed({2'b00, cursor_x_q}) + dx_s;
  // PS/2 positive dy is upward, screen y grows downward.
  assign y_sum     = $signed({2'b00, cursor_y_q}) - dy_s;
  assign nx        = ovf ? cursor_x_q : clamp(x_sum, X_MAX);
  assign ny        = ovf ? cursor_y_q : clamp(y_sum, Y_MAX);

  // Packet assembly: B0 must carry the always-one bit 3 to resync the stream.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    case (state_q)
      ST_B0: begin
        tmo_d = '0;
        if (rx_valid && rx_data[3]) begin
          b0_d    = rx_data;
          state_d = ST_B1;
        end
      end
      ST_B1: begin
        if (rx_valid) begin
          b1_d    = rx_data;
          tmo_d   = '0;
          state_d = ST_B2;
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = ST_B0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_B2: begin
        if (rx_valid) begin
          b2_d    = rx_data;
          tmo_d   = '0;
          state_d = ST_UPD;
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = ST_B0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        tmo_d   = '0;
        state_d = ST_B0;
      end
    endcase
  end

  // Cursor / selection update and event generation.
  always_comb begin
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    anchor_x_d   = anchor_x_q;
    anchor_y_d   = anchor_y_q;
    left_pos_x_d = left_pos_x_q;
    bot_pos_y_d  = bot_pos_y_q;
    sel_length_d = sel_length_q;
    sel_active_d = sel_active_q;
    left_hist_d  = left_hist_q;
    right_hist_d = right_hist_q;
    click_d      = 1'b0;
    zoom_d       = 1'b0;
    restore_d    = 1'b0;
    if (en_rise) begin
      // Reload wins over a packet update landing in the same cycle.
      cursor_x_d   = cursor_x_orig;
      cursor_y_d   = cursor_y_orig;
      left_hist_d  = 1'b0;
      right_hist_d = 1'b0;
      sel_active_d = 1'b0;
    end else if (!mouse_en) begin
      sel_active_d = 1'b0;
    end else if (state_q == ST_UPD) begin
      cursor_x_d   = nx;
      cursor_y_d   = ny;
      left_hist_d  = left_btn;
      right_hist_d = right_btn;
      if (right_btn && !right_hist_q) begin
        // Restore cancels any drag without producing click/zoom.
        restore_d    = 1'b1;
        sel_active_d = 1'b0;
      end else if (left_btn && !left_hist_q) begin
        anchor_x_d   = nx;
        anchor_y_d   = ny;
        sel_active_d = 1'b1;
        sel_length_d = 10'd0;
        left_pos_x_d = nx;
        bot_pos_y_d  = ny;
      end else if (sel_active_q && left_btn) begin
        sel_length_d = sel_len(nx, anchor_x_q, ny, anchor_y_q);
        left_pos_x_d = (nx < anchor_x_q) ? nx : anchor_x_q;
        bot_pos_y_d  = (ny > anchor_y_q) ? ny : anchor_y_q;
      end else if (sel_active_q && !left_btn) begin
        if (sel_length_q >= 10'(MIN_SEL)) zoom_d = 1'b1;
        else                              click_d = 1'b1;
        sel_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_B0;
      tmo_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      en_prev_q    <= 1'b0;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      anchor_x_q   <= '0;
      anchor_y_q   <= '0;
      left_pos_x_q <= '0;
      bot_pos_y_q  <= '0;
      sel_length_q <= '0;
      sel_active_q <= 1'b0;
      left_hist_q  <= 1'b0;
      right_hist_q <= 1'b0;
      click_q      <= 1'b0;
      zoom_q       <= 1'b0;
      restore_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      en_prev_q    <= mouse_en;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      anchor_x_q   <= anchor_x_d;
      anchor_y_q   <= anchor_y_d;
      left_pos_x_q <= left_pos_x_d;
      bot_pos_y_q  <= bot_pos_y_d;
      sel_length_q <= sel_length_d;
      sel_active_q <= sel_active_d;
      left_hist_q  <= left_hist_d;
      right_hist_q <= right_hist_d;
      click_q      <= click_d;
      zoom_q       <= zoom_d;
      restore_q    <= restore_d;
    end
  end

  assign cursor_x      = cursor_x_q;
  assign cursor_y      = cursor_y_q;
  assign left_pos_x    = left_pos_x_q;
  assign bot_pos_y     = bot_pos_y_q;
  assign sel_length    = sel_length_q;
  assign sel_active    = sel_active_q;
  assign mouse_click   = click_q;
  assign mouse_zoom    = zoom_q;
  assign mouse_restore = restore_q;

endmodule
